// File: rtl/alu0_issue_select.sv
// rtl/alu0_issue_select.sv - ALU0 collapsing issue queue with oldest-first select and wakeup
// Entry 0 is always the oldest; selected entries are removed and younger ones shift down.
module alu0_issue_select #(
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     disp_vld,
   output logic                     disp_rdy,
   input  logic [4:0]               disp_op,
   input  logic [19:0]              disp_imm,
   input  logic [5:0]               disp_dest,
   input  logic [5:0]               disp_src1,
   input  logic [5:0]               disp_src2,
   input  logic [5:0]               disp_rob_id,
   input  logic                     disp_src1_rdy,
   input  logic                     disp_src2_rdy,
   input  logic                     wk0_vld,
   input  logic [5:0]               wk0_tag,
   input  logic                     wk1_vld,
   input  logic [5:0]               wk1_tag,
   input  logic                     alu0_stall,
   input  logic                     flush,
   output logic                     ALU0_select_vld,
   output logic [4:0]               ALU0_select_op,
   output logic [19:0]              ALU0_select_imm,
   output logic [5:0]               ALU0_select_dest,
   output logic [5:0]               ALU0_select_source1,
   output logic [5:0]               ALU0_select_source2,
   output logic [5:0]               ALU0_select_ROB_ID,
   output logic [$clog2(DEPTH):0]   iq_count
);

   localparam int IW = $clog2(DEPTH);
   localparam int CW = IW + 1;

   logic        e_vld  [DEPTH];
   logic [4:0]  e_op   [DEPTH];
   logic [19:0] e_imm  [DEPTH];
   logic [5:0]  e_dest [DEPTH];
   logic [5:0]  e_src1 [DEPTH];
   logic [5:0]  e_src2 [DEPTH];
   logic [5:0]  e_rob  [DEPTH];
   logic        e_rdy1 [DEPTH];
   logic        e_rdy2 [DEPTH];

   logic        n_vld  [DEPTH];
   logic [4:0]  n_op   [DEPTH];
   logic [19:0] n_imm  [DEPTH];
   logic [5:0]  n_dest [DEPTH];
   logic [5:0]  n_src1 [DEPTH];
   logic [5:0]  n_src2 [DEPTH];
   logic [5:0]  n_rob  [DEPTH];
   logic        n_rdy1 [DEPTH];
   logic        n_rdy2 [DEPTH];

   logic [DEPTH-1:0] w_rdy1;
   logic [DEPTH-1:0] w_rdy2;
   logic [DEPTH-1:0] elig;
   logic             sel_any;
   logic [IW-1:0]    sel_idx;
   logic             issue;
   logic             disp_acc;
   logic [CW-1:0]    app_idx;

   function automatic logic tag_match(input logic [5:0] tag, input logic v, input logic [5:0] t);
      return v && (t == tag);
   endfunction

   function automatic logic wake(input logic [5:0] tag,
                                 input logic v0, input logic [5:0] t0,
                                 input logic v1, input logic [5:0] t1,
                                 input logic v2, input logic [5:0] t2);
      return tag_match(tag, v0, t0) || tag_match(tag, v1, t1) || tag_match(tag, v2, t2);
   endfunction

   // The result being issued right now forwards combinationally into select so a
   // dependent single-cycle op can issue back-to-back; external wakeups act next cycle.
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         w_rdy1[i] = e_rdy1[i] | wake(e_src1[i], wk0_vld, wk0_tag, wk1_vld, wk1_tag,
                                      ALU0_select_vld, ALU0_select_dest);
         w_rdy2[i] = e_rdy2[i] | wake(e_src2[i], wk0_vld, wk0_tag, wk1_vld, wk1_tag,
                                      ALU0_select_vld, ALU0_select_dest);
         elig[i]   = e_vld[i]
                     & (e_rdy1[i] | tag_match(e_src1[i], ALU0_select_vld, ALU0_select_dest))
                     & (e_rdy2[i] | tag_match(e_src2[i], ALU0_select_vld, ALU0_select_dest));
      end
   end

   always_comb begin
      sel_any = 1'b0;
      sel_idx = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (elig[i]) begin
            sel_any = 1'b1;
            sel_idx = IW'(i);
         end
      end
   end

   assign disp_rdy = (iq_count < CW'(DEPTH));
   assign issue    = sel_any && !alu0_stall && !flush;
   assign disp_acc = disp_vld && disp_rdy && !flush;
   assign app_idx  = iq_count - CW'(issue);

   always_comb begin
      int src;
      for (int i = 0; i < DEPTH; i++) begin
         n_vld[i]  = 1'b0;
         n_op[i]   = '0;
         n_imm[i]  = '0;
         n_dest[i] = '0;
         n_src1[i] = '0;
         n_src2[i] = '0;
         n_rob[i]  = '0;
         n_rdy1[i] = 1'b0;
         n_rdy2[i] = 1'b0;
         src = (issue && (i >= int'(sel_idx))) ? i + 1 : i;
         if (src < DEPTH) begin
            n_vld[i]  = e_vld[IW'(src)];
            n_op[i]   = e_op[IW'(src)];
            n_imm[i]  = e_imm[IW'(src)];
            n_dest[i] = e_dest[IW'(src)];
            n_src1[i] = e_src1[IW'(src)];
            n_src2[i] = e_src2[IW'(src)];
            n_rob[i]  = e_rob[IW'(src)];
            n_rdy1[i] = w_rdy1[IW'(src)];
            n_rdy2[i] = w_rdy2[IW'(src)];
         end
         // New entry lands just above the post-collapse top.
         if (disp_acc && (int'(app_idx) == i)) begin
            n_vld[i]  = 1'b1;
            n_op[i]   = disp_op;
            n_imm[i]  = disp_imm;
            n_dest[i] = disp_dest;
            n_src1[i] = disp_src1;
            n_src2[i] = disp_src2;
            n_rob[i]  = disp_rob_id;
            n_rdy1[i] = disp_src1_rdy | wake(disp_src1, wk0_vld, wk0_tag, wk1_vld, wk1_tag,
                                             ALU0_select_vld, ALU0_select_dest);
            n_rdy2[i] = disp_src2_rdy | wake(disp_src2, wk0_vld, wk0_tag, wk1_vld, wk1_tag,
                                             ALU0_select_vld, ALU0_select_dest);
         end
         if (flush) begin
            n_vld[i] = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         e_vld               <= '{default: '0};
         e_op                <= '{default: '0};
         e_imm               <= '{default: '0};
         e_dest              <= '{default: '0};
         e_src1              <= '{default: '0};
         e_src2              <= '{default: '0};
         e_rob               <= '{default: '0};
         e_rdy1              <= '{default: '0};
         e_rdy2              <= '{default: '0};
         iq_count            <= '0;
         ALU0_select_vld     <= 1'b0;
         ALU0_select_op      <= '0;
         ALU0_select_imm     <= '0;
         ALU0_select_dest    <= '0;
         ALU0_select_source1 <= '0;
         ALU0_select_source2 <= '0;
         ALU0_select_ROB_ID  <= '0;
      end else begin
         e_vld  <= n_vld;
         e_op   <= n_op;
         e_imm  <= n_imm;
         e_dest <= n_dest;
         e_src1 <= n_src1;
         e_src2 <= n_src2;
         e_rob  <= n_rob;
         e_rdy1 <= n_rdy1;
         e_rdy2 <= n_rdy2;
         if (flush) begin
            iq_count <= '0;
         end else begin
            iq_count <= iq_count + CW'(disp_acc) - CW'(issue);
         end
         ALU0_select_vld <= issue;
         if (issue) begin
            ALU0_select_op      <= e_op[sel_idx];
            ALU0_select_imm     <= e_imm[sel_idx];
            ALU0_select_dest    <= e_dest[sel_idx];
            ALU0_select_source1 <= e_src1[sel_idx];
            ALU0_select_source2 <= e_src2[sel_idx];
            ALU0_select_ROB_ID  <= e_rob[sel_idx];
         end
      end
   end

endmodule

// File: tb/tb_alu0_issue_select.sv
// tb/tb_alu0_issue_select.sv - scoreboard bench for alu0_issue_select
// Stimulus pushes expected issues (fields and cycle); a negedge monitor pops and compares.
module tb_alu0_issue_select;

   localparam int DEPTH = 8;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        disp_vld, disp_rdy;
   logic [4:0]  disp_op;
   logic [19:0] disp_imm;
   logic [5:0]  disp_dest, disp_src1, disp_src2, disp_rob_id;
   logic        disp_src1_rdy, disp_src2_rdy;
   logic        wk0_vld, wk1_vld;
   logic [5:0]  wk0_tag, wk1_tag;
   logic        alu0_stall, flush;
   logic        ALU0_select_vld;
   logic [4:0]  ALU0_select_op;
   logic [19:0] ALU0_select_imm;
   logic [5:0]  ALU0_select_dest, ALU0_select_source1, ALU0_select_source2, ALU0_select_ROB_ID;
   logic [$clog2(DEPTH):0] iq_count;

   alu0_issue_select #(.DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n),
      .disp_vld(disp_vld), .disp_rdy(disp_rdy),
      .disp_op(disp_op), .disp_imm(disp_imm), .disp_dest(disp_dest),
      .disp_src1(disp_src1), .disp_src2(disp_src2), .disp_rob_id(disp_rob_id),
      .disp_src1_rdy(disp_src1_rdy), .disp_src2_rdy(disp_src2_rdy),
      .wk0_vld(wk0_vld), .wk0_tag(wk0_tag), .wk1_vld(wk1_vld), .wk1_tag(wk1_tag),
      .alu0_stall(alu0_stall), .flush(flush),
      .ALU0_select_vld(ALU0_select_vld), .ALU0_select_op(ALU0_select_op),
      .ALU0_select_imm(ALU0_select_imm), .ALU0_select_dest(ALU0_select_dest),
      .ALU0_select_source1(ALU0_select_source1), .ALU0_select_source2(ALU0_select_source2),
      .ALU0_select_ROB_ID(ALU0_select_ROB_ID), .iq_count(iq_count)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   typedef struct {
      logic [5:0]  rob, dest, s1, s2;
      logic [4:0]  op;
      logic [19:0] imm;
      int          c;
   } exp_t;

   exp_t sb[$];
   int   n_run = 0;
   int   n_fail = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_run++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic exp_t mk(input logic [5:0] rob, input logic [5:0] dest,
                               input logic [5:0] s1, input logic [5:0] s2, input int c);
      exp_t e;
      e.rob = rob; e.dest = dest; e.s1 = s1; e.s2 = s2;
      e.op  = rob[4:0] ^ 5'h15;
      e.imm = {rob, dest, 8'hA5};
      e.c   = c;
      return e;
   endfunction

   always @(negedge clk) begin
      if (rst_n && ALU0_select_vld) begin
         if (sb.size() == 0) begin
            n_run++;
            n_fail++;
            $display("FAIL unexpected_issue: got rob %0d, expected no issue (cycle %0d)",
                     ALU0_select_ROB_ID, cyc);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("issue_fields",
                  {15'd0, ALU0_select_ROB_ID, ALU0_select_dest, ALU0_select_op,
                   ALU0_select_imm, ALU0_select_source1, ALU0_select_source2},
                  {15'd0, e.rob, e.dest, e.op, e.imm, e.s1, e.s2});
            if (e.c >= 0) check("issue_cycle", 64'(cyc), 64'(e.c));
         end
      end
   end

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic idle();
      disp_vld = 1'b0; wk0_vld = 1'b0; wk1_vld = 1'b0; flush = 1'b0;
   endtask

   task automatic put(input logic [5:0] rob, input logic [5:0] dest,
                      input logic [5:0] s1, input logic r1,
                      input logic [5:0] s2, input logic r2);
      disp_vld = 1'b1; disp_rob_id = rob; disp_dest = dest;
      disp_src1 = s1; disp_src1_rdy = r1; disp_src2 = s2; disp_src2_rdy = r2;
      disp_op = rob[4:0] ^ 5'h15;
      disp_imm = {rob, dest, 8'hA5};
   endtask

   initial begin
      int c;
      idle();
      alu0_stall = 1'b0;
      disp_op = '0; disp_imm = '0; disp_dest = '0; disp_src1 = '0; disp_src2 = '0;
      disp_rob_id = '0; disp_src1_rdy = 1'b0; disp_src2_rdy = 1'b0;
      wk0_tag = '0; wk1_tag = '0;
      step(3);
      @(negedge clk) rst_n = 1'b1;
      step();
      check("rst_count", 64'(iq_count), 0);
      check("rst_disp_rdy", 64'(disp_rdy), 1);
      check("rst_vld", 64'(ALU0_select_vld), 0);
      check("rst_rob", 64'(ALU0_select_ROB_ID), 0);
      check("rst_dest", 64'(ALU0_select_dest), 0);

      // single ready op into an empty queue
      put(5, 12, 1, 1, 2, 1); sb.push_back(mk(5, 12, 1, 2, cyc + 2)); step(); idle();
      check("single_count_1", 64'(iq_count), 1);
      step();
      check("single_count_0", 64'(iq_count), 0);
      step(2);

      // younger ready op bypasses older waiting op; external wakeup releases it
      put(10, 40, 20, 0, 21, 1); step();
      put(11, 41, 3, 1, 4, 1); sb.push_back(mk(11, 41, 3, 4, cyc + 2)); step(); idle();
      step(3);
      wk0_vld = 1'b1; wk0_tag = 20; sb.push_back(mk(10, 40, 20, 21, cyc + 2)); step(); idle();
      step(3);

      // wakeup on wk1 coincident with dispatch
      put(12, 42, 5, 1, 23, 0); wk1_vld = 1'b1; wk1_tag = 23;
      sb.push_back(mk(12, 42, 5, 23, cyc + 2)); step(); idle();
      step(3);

      // back-to-back dependent chain via internal wakeup
      put(20, 30, 6, 1, 7, 1); sb.push_back(mk(20, 30, 6, 7, cyc + 2)); step();
      put(21, 31, 30, 0, 8, 1); sb.push_back(mk(21, 31, 30, 8, cyc + 2)); step(); idle();
      step();
      put(22, 43, 31, 0, 9, 1); sb.push_back(mk(22, 43, 31, 9, cyc + 2)); step(); idle();
      step(3);

      // fill the queue with waiting ops
      for (int i = 0; i < DEPTH; i++) begin
         put(6'(32 + i), 6'(8 + i), 6'(50 + i), 0, 10, 1);
         step();
      end
      idle();
      check("full_count", 64'(iq_count), DEPTH);
      check("full_disp_rdy", 64'(disp_rdy), 0);
      put(40, 20, 11, 1, 12, 1); step(); idle();
      check("full_ignore", 64'(iq_count), DEPTH);
      wk0_vld = 1'b1; wk0_tag = 50; sb.push_back(mk(32, 8, 50, 10, cyc + 2)); step(); idle();
      check("full_rdy_hold", 64'(disp_rdy), 0);
      step();
      check("full_rdy_free", 64'(disp_rdy), 1);
      check("full_count_7", 64'(iq_count), DEPTH - 1);
      wk0_vld = 1'b1; wk0_tag = 57; wk1_vld = 1'b1; wk1_tag = 51;
      sb.push_back(mk(33, 9, 51, 10, cyc + 2)); sb.push_back(mk(39, 15, 57, 10, cyc + 3));
      step(); idle(); step();
      wk0_vld = 1'b1; wk0_tag = 52; wk1_vld = 1'b1; wk1_tag = 53;
      sb.push_back(mk(34, 10, 52, 10, cyc + 2)); sb.push_back(mk(35, 11, 53, 10, cyc + 3));
      step(); idle(); step();
      wk0_vld = 1'b1; wk0_tag = 54; wk1_vld = 1'b1; wk1_tag = 55;
      sb.push_back(mk(36, 12, 54, 10, cyc + 2)); sb.push_back(mk(37, 13, 55, 10, cyc + 3));
      step(); idle(); step();
      wk0_vld = 1'b1; wk0_tag = 56; sb.push_back(mk(38, 14, 56, 10, cyc + 2));
      step(); idle(); step(3);
      check("drain_count", 64'(iq_count), 0);

      // stall held three cycles over ready entries
      c = cyc;
      put(41, 16, 17, 1, 18, 1); step();
      alu0_stall = 1'b1; put(42, 17, 19, 1, 20, 1); step();
      check("stall_vld_1", 64'(ALU0_select_vld), 0);
      put(43, 18, 21, 1, 22, 1); step(); idle();
      check("stall_vld_2", 64'(ALU0_select_vld), 0);
      step();
      check("stall_vld_3", 64'(ALU0_select_vld), 0);
      check("stall_count", 64'(iq_count), 3);
      alu0_stall = 1'b0;
      sb.push_back(mk(41, 16, 17, 18, c + 5));
      sb.push_back(mk(42, 17, 19, 20, c + 6));
      sb.push_back(mk(43, 18, 21, 22, c + 7));
      step(4);

      // flush with five entries, a selectable entry and a concurrent dispatch
      for (int i = 0; i < 4; i++) begin
         put(6'(51 + i), 6'(21 + i), 58, 0, 19, 1);
         step();
      end
      put(50, 25, 26, 1, 27, 1); step();
      check("flush_pre_count", 64'(iq_count), 5);
      put(55, 28, 29, 1, 30, 1); flush = 1'b1; step(); idle();
      check("flush_count", 64'(iq_count), 0);
      check("flush_vld", 64'(ALU0_select_vld), 0);
      check("flush_disp_rdy", 64'(disp_rdy), 1);
      wk0_vld = 1'b1; wk0_tag = 58; step(); idle(); step(5);
      check("flush_after_count", 64'(iq_count), 0);

      // asynchronous reset while a ready entry is about to issue
      put(60, 31, 32, 1, 33, 1); step(); idle();
      #2 rst_n = 1'b0;
      #1;
      check("arst_count", 64'(iq_count), 0);
      check("arst_vld", 64'(ALU0_select_vld), 0);
      @(negedge clk) rst_n = 1'b1;
      step(5);
      check("arst_post_count", 64'(iq_count), 0);

      check("scoreboard_empty", 64'(sb.size()), 0);
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule

// File: doc/alu0_issue_select.md
ALU0_ISSUE_SELECT -- requirements
Module: alu0_issue_select

Interface
REQ-001 Parameter DEPTH, default 8, number of issue-queue entries (power of 2, 4..16).
REQ-002 clk  in  1  clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 disp_vld  in  1  dispatch request; disp_rdy  out  1  queue can accept this cycle.
REQ-005 disp_op  in  5; disp_imm  in  20; disp_dest  in  6; disp_src1/disp_src2  in  6 each; disp_rob_id  in  6: instruction fields.
REQ-006 disp_src1_rdy/disp_src2_rdy  in  1 each  operand already available at dispatch.
REQ-007 wk0_vld/wk1_vld  in  1 each; wk0_tag/wk1_tag  in  6 each  external physical-register wakeup broadcasts.
REQ-008 alu0_stall  in  1  downstream cannot take an instruction next cycle.
REQ-009 flush  in  1  pipeline flush (mispredict/exception).
REQ-010 ALU0_select_vld  out  1; ALU0_select_op  out  5; ALU0_select_imm  out  20; ALU0_select_dest  out  6; ALU0_select_source1/ALU0_select_source2  out  6 each; ALU0_select_ROB_ID  out  6: registered issue to read stage.
REQ-011 iq_count  out  log2(DEPTH)+1  number of valid entries.

Function
REQ-012 Queue is collapsing: entry 0 oldest; valid entries always contiguous from index 0.
REQ-013 Each entry holds valid, all dispatch fields, rdy1, rdy2.
REQ-014 disp_rdy = (iq_count < DEPTH), from registered count only; no same-cycle credit from issue.
REQ-015 Dispatch accepted when disp_vld && disp_rdy && !flush; entry written at edge.
REQ-016 Dispatch rdyN = disp_srcN_rdy OR srcN matches any valid wakeup tag this cycle (wk0, wk1, or internal wakeup REQ-019).
REQ-017 Resident entry: rdyN set at edge when srcN matches any valid wakeup tag; rdy bits never clear except by entry removal.
REQ-018 Select: among valid entries with rdy1 && rdy2, lowest index wins; none selected when alu0_stall or flush high.
REQ-019 Internal wakeup: when ALU0_select_vld is high, ALU0_select_dest acts as a third wakeup tag (single-cycle ALU back-to-back issue).
REQ-020 On selection: output registers load winner fields, ALU0_select_vld=1 next cycle; winner removed, entries above shift down by one.
REQ-021 No selection: ALU0_select_vld=0 next cycle; other ALU0_select_* outputs hold previous values.
REQ-022 Simultaneous dispatch and issue: collapse first, new entry appended at index (iq_count-1); iq_count unchanged.
REQ-023 Wakeup and shift same cycle: wakeup applies to the entry in its new position.
REQ-024 Latency: dispatch with both operands ready in cycle N, empty queue, no stall -> ALU0_select_vld high in cycle N+2.
REQ-025 Max one issue per cycle; iq_count = old + accepted dispatch - issue, never exceeds DEPTH nor underflows.
REQ-026 flush: all entries invalidated, iq_count=0, ALU0_select_vld=0 at next edge; concurrent dispatch and selection discarded.

Reset
REQ-027 rst_n low: all entry valid=0, iq_count=0, ALU0_select_vld=0, disp_rdy=1 after release; other ALU0_select_* fields reset to 0.
REQ-028 Reset asserted mid-operation discards all entries and any pending issue immediately (asynchronous).

Verification
REQ-029 Reset, dispatch rob_id=5 src1/src2 ready, dest=12 -> ALU0_select_vld=1, ROB_ID=5, dest=12 two cycles later; iq_count returns 0.
REQ-030 Dispatch A(src1=20 not ready), then B(ready) -> B issues first; wk0 tag=20 -> A issues exactly two cycles after wakeup.
REQ-031 Chain: A dest=30 ready, B src1=30 -> A issues cycle N, B issues cycle N+1 via internal wakeup.
REQ-032 Fill DEPTH unready entries -> disp_rdy=0, extra disp_vld ignored; wake oldest -> disp_rdy=1 the cycle after issue, oldest-first order kept.
REQ-033 alu0_stall held 3 cycles with ready entries -> ALU0_select_vld=0 during stall+1, no entry lost; resumes in age order.
REQ-034 flush with 5 entries and concurrent dispatch -> next cycle iq_count=0, ALU0_select_vld=0, no later issue of flushed ROB_IDs.
